// File: rtl/sdram_pkg.sv
// Shared definitions for the two-port SDRAM arbiter.
// Holds the arbiter state encoding and the default bus widths.
package sdram_pkg;

    localparam int SDRAM_AW = 23;
    localparam int SDRAM_LW = 9;
    localparam int SDRAM_DW = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        XFER,
        DONE
    } arb_state_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// Two-way grant selection for the SDRAM arbiter.
// SDRAM_ARB_RR_EN: round-robin via a last-served flop; else port 0 first.
module sdram_arb_pick (
`ifdef SDRAM_ARB_RR_EN
    input  logic clk,
    input  logic reset,
    input  logic i_take,
`endif
    input  logic i_req0,
    input  logic i_req1,
    output logic o_any,
    output logic o_sel
);

    assign o_any = i_req0 | i_req1;

`ifdef SDRAM_ARB_RR_EN
    // r_last = 1 means port 1 won the previous grant
    logic r_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (i_take) begin
            r_last <= o_sel;
        end
    end

    assign o_sel = i_req1 & (~i_req0 | ~r_last);
`else
    assign o_sel = i_req1 & ~i_req0;
`endif

endmodule

// File: rtl/sdram_arbiter.sv
// Shares sdram_top's burst interface between video (port 0) and CPU (port 1).
// Define SDRAM_ARB_RR_EN for round-robin instead of fixed port-0 priority.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int AW = SDRAM_AW,
    parameter int LW = SDRAM_LW,
    parameter int DW = SDRAM_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic [AW-1:0] p0_addr,
    input  logic [LW-1:0] p0_len,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    output logic          p0_done,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [LW-1:0] p1_len,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_wstrobe,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          p1_done,
    output logic          err,
    input  logic          sdram_init_done,
    output logic          sdram_wr_req,
    output logic          sdram_rd_req,
    input  logic          sdram_wr_ack,
    input  logic          sdram_rd_ack,
    output logic [AW-1:0] sys_wraddr,
    output logic [AW-1:0] sys_rdaddr,
    output logic [LW-1:0] sdwr_byte,
    output logic [LW-1:0] sdrd_byte,
    output logic [DW-1:0] sys_data_in,
    input  logic [DW-1:0] sys_data_out
);

    arb_state_t  r_state;
    arb_state_t  w_next;
    logic        r_gnt;
    logic        r_port;
    logic        r_we;
    logic [AW-1:0] r_addr;
    logic [LW-1:0] r_len;
    logic [LW:0]   r_beats;
    logic        r_err;

    logic        w_any;
    logic        w_sel;
    logic        w_take;
    logic        w_ack;
    logic        w_rd;
    logic        w_wr;
    logic        w_req_we;
    logic [AW-1:0] w_req_addr;
    logic [LW-1:0] w_req_len;

    sdram_arb_pick u_pick (
`ifdef SDRAM_ARB_RR_EN
        .clk    (clk),
        .reset  (reset),
        .i_take (w_take),
`endif
        .i_req0 (p0_req),
        .i_req1 (p1_req),
        .o_any  (w_any),
        .o_sel  (w_sel)
    );

    assign w_take     = (r_state == IDLE) & sdram_init_done & w_any;
    assign w_req_we   = w_sel & p1_we;
    assign w_req_addr = w_sel ? p1_addr : p0_addr;
    assign w_req_len  = w_sel ? p1_len : p0_len;
    // only the ack matching the latched direction counts
    assign w_ack      = r_we ? sdram_wr_ack : sdram_rd_ack;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_take) begin
                    w_next = (w_req_len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (w_ack) w_next = XFER;
            end
            XFER: begin
                if (!w_ack) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt   <= 1'b0;
            r_port  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_beats <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_take) begin
                r_gnt   <= 1'b1;
                r_port  <= w_sel;
                r_we    <= w_req_we;
                r_addr  <= w_req_addr;
                r_len   <= w_req_len;
                r_beats <= '0;
            end
            if (r_state == ISSUE && w_ack) begin
                r_beats <= {{LW{1'b0}}, 1'b1};
            end
            if (r_state == XFER && w_ack && r_beats != '1) begin
                r_beats <= r_beats + 1'b1;
            end
            if (r_state == DONE) begin
                r_gnt <= 1'b0;
                if (r_len != '0 && r_beats != {1'b0, r_len}) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign w_rd = r_gnt & ~r_we;
    assign w_wr = r_gnt & r_we;

    assign sdram_rd_req = (r_state == ISSUE) & ~r_we;
    assign sdram_wr_req = (r_state == ISSUE) & r_we;
    assign sys_rdaddr   = w_rd ? r_addr : '0;
    assign sdrd_byte    = w_rd ? r_len : '0;
    assign sys_wraddr   = w_wr ? r_addr : '0;
    assign sdwr_byte    = w_wr ? r_len : '0;
    assign sys_data_in  = p1_wdata;

    assign p1_wstrobe = sdram_wr_ack & w_wr & r_port;
    assign p0_rvalid  = sdram_rd_ack & w_rd & ~r_port;
    assign p1_rvalid  = sdram_rd_ack & w_rd & r_port;
    assign p0_rdata   = sys_data_out;
    assign p1_rdata   = sys_data_out;
    assign p0_done    = (r_state == DONE) & ~r_port;
    assign p1_done    = (r_state == DONE) & r_port;
    assign err        = r_err;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter with a behavioural sdram_top model.
module tb_sdram_arbiter;

    localparam int AW = 23;
    localparam int LW = 9;
    localparam int DW = 16;

    logic          clk;
    logic          reset;
    logic          p0_req;
    logic [AW-1:0] p0_addr;
    logic [LW-1:0] p0_len;
    logic          p0_rvalid;
    logic [DW-1:0] p0_rdata;
    logic          p0_done;
    logic          p1_req;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [LW-1:0] p1_len;
    logic [DW-1:0] p1_wdata;
    logic          p1_wstrobe;
    logic          p1_rvalid;
    logic [DW-1:0] p1_rdata;
    logic          p1_done;
    logic          err;
    logic          sdram_init_done;
    logic          sdram_wr_req;
    logic          sdram_rd_req;
    logic          sdram_wr_ack;
    logic          sdram_rd_ack;
    logic [AW-1:0] sys_wraddr;
    logic [AW-1:0] sys_rdaddr;
    logic [LW-1:0] sdwr_byte;
    logic [LW-1:0] sdrd_byte;
    logic [DW-1:0] sys_data_in;
    logic [DW-1:0] sys_data_out;

    sdram_arbiter #(.AW(AW), .LW(LW), .DW(DW)) dut (
        .clk             (clk),
        .reset           (reset),
        .p0_req          (p0_req),
        .p0_addr         (p0_addr),
        .p0_len          (p0_len),
        .p0_rvalid       (p0_rvalid),
        .p0_rdata        (p0_rdata),
        .p0_done         (p0_done),
        .p1_req          (p1_req),
        .p1_we           (p1_we),
        .p1_addr         (p1_addr),
        .p1_len          (p1_len),
        .p1_wdata        (p1_wdata),
        .p1_wstrobe      (p1_wstrobe),
        .p1_rvalid       (p1_rvalid),
        .p1_rdata        (p1_rdata),
        .p1_done         (p1_done),
        .err             (err),
        .sdram_init_done (sdram_init_done),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_rd_req    (sdram_rd_req),
        .sdram_wr_ack    (sdram_wr_ack),
        .sdram_rd_ack    (sdram_rd_ack),
        .sys_wraddr      (sys_wraddr),
        .sys_rdaddr      (sys_rdaddr),
        .sdwr_byte       (sdwr_byte),
        .sdrd_byte       (sdrd_byte),
        .sys_data_in     (sys_data_in),
        .sys_data_out    (sys_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // sdram_top model: 2-cycle latency then a run of acks
    logic [DW-1:0] mem [0:255];
    logic          m_busy;
    logic          m_wr;
    logic [7:0]    m_base;
    logic [7:0]    m_widx;
    logic [LW-1:0] m_n;
    logic [LW-1:0] m_idx;
    logic [1:0]    m_dly;
    logic [LW-1:0] short_n;
    logic [DW-1:0] wcnt;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
    end

    assign p1_wdata = wcnt;

    always @(posedge clk) begin
        if (reset) begin
            m_busy       <= 1'b0;
            m_wr         <= 1'b0;
            m_base       <= '0;
            m_widx       <= '0;
            m_n          <= '0;
            m_idx        <= '0;
            m_dly        <= '0;
            sdram_wr_ack <= 1'b0;
            sdram_rd_ack <= 1'b0;
            sys_data_out <= '0;
            wcnt         <= '0;
        end else begin
            if (p1_wstrobe) wcnt <= wcnt + 1'b1;
            if (sdram_wr_ack) begin
                mem[m_base + m_widx] <= sys_data_in;
                m_widx <= m_widx + 1'b1;
            end
            if (!m_busy) begin
                if (sdram_wr_req || sdram_rd_req) begin
                    m_busy <= 1'b1;
                    m_wr   <= sdram_wr_req;
                    m_base <= sdram_wr_req ? sys_wraddr[7:0] : sys_rdaddr[7:0];
                    m_n    <= (short_n != 0) ? short_n
                            : (sdram_wr_req ? sdwr_byte : sdrd_byte);
                    m_idx  <= '0;
                    m_widx <= '0;
                    m_dly  <= 2'd2;
                end
            end else if (m_dly != 0) begin
                m_dly <= m_dly - 1'b1;
            end else if (m_idx < m_n) begin
                if (m_wr) begin
                    sdram_wr_ack <= 1'b1;
                end else begin
                    sdram_rd_ack <= 1'b1;
                    sys_data_out <= mem[m_base + m_idx[7:0]];
                end
                m_idx <= m_idx + 1'b1;
            end else begin
                sdram_wr_ack <= 1'b0;
                sdram_rd_ack <= 1'b0;
                m_busy       <= 1'b0;
            end
        end
    end

    typedef struct {
        logic port;
        logic err;
    } done_t;

    logic [DW-1:0] exp_rd0 [$];
    logic [DW-1:0] exp_rd1 [$];
    done_t         exp_done [$];
    logic          seen0;
    logic          seen1;
    logic          err_pend;
    logic          err_exp;
    int            n_strobe;
    int            n_rv1;

    // monitor: pops expectations whenever the DUT presents an event
    always @(negedge clk) begin
        if (err_pend) begin
            chk("err_after_done", {31'd0, err}, {31'd0, err_exp});
            err_pend = 1'b0;
        end
        if (p1_wstrobe) n_strobe++;
        if (p0_rvalid) begin
            chk("p0_rd_expected", {31'd0, exp_rd0.size() != 0}, 32'd1);
            if (exp_rd0.size() != 0)
                chk("p0_rdata", {16'd0, p0_rdata}, {16'd0, exp_rd0.pop_front()});
        end
        if (p1_rvalid) begin
            n_rv1++;
            chk("p1_rd_expected", {31'd0, exp_rd1.size() != 0}, 32'd1);
            if (exp_rd1.size() != 0)
                chk("p1_rdata", {16'd0, p1_rdata}, {16'd0, exp_rd1.pop_front()});
        end
        if (p0_done || p1_done) begin
            chk("done_expected", {31'd0, exp_done.size() != 0}, 32'd1);
            if (exp_done.size() != 0) begin
                done_t d;
                d = exp_done.pop_front();
                chk("done_port", {30'd0, p1_done, p0_done},
                    d.port ? 32'd2 : 32'd1);
                err_exp  = d.err;
                err_pend = 1'b1;
            end
            if (p0_done) seen0 = 1'b1;
            if (p1_done) seen1 = 1'b1;
        end
    end

    task automatic wait_done(input string name);
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (seen0) p0_req = 1'b0;
            if (seen1) p1_req = 1'b0;
            if (exp_done.size() == 0) break;
        end
        chk({name, "_timeout"}, exp_done.size(), 32'd0);
        p0_req = 1'b0;
        p1_req = 1'b0;
        seen0  = 1'b0;
        seen1  = 1'b0;
    endtask

    task automatic push_done(input logic port, input logic e);
        done_t d;
        d.port = port;
        d.err  = e;
        exp_done.push_back(d);
    endtask

    function automatic logic [31:0] outs_or();
        return {18'd0, sdram_wr_req, sdram_rd_req, p0_rvalid, p1_rvalid,
                p0_done, p1_done, p1_wstrobe, err, |sys_wraddr,
                |sys_rdaddr, |sdwr_byte, |sdrd_byte, |p0_rdata, |p1_rdata};
    endfunction

    initial begin
        int dcyc;
        logic anyreq;
        reset = 1'b1;
        sdram_init_done = 1'b0;
        p0_req = 0; p0_addr = '0; p0_len = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_len = '0;
        short_n = '0;
        seen0 = 0; seen1 = 0; err_pend = 0; err_exp = 0;
        n_strobe = 0; n_rv1 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", outs_or(), 32'd0);
        reset = 1'b0;

        // init gating
        p0_addr = 23'h10; p0_len = 9'd2; p0_req = 1'b1;
        exp_rd0.push_back(16'hA010); exp_rd0.push_back(16'hA011);
        push_done(1'b0, 1'b0);
        anyreq = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            anyreq |= sdram_rd_req | sdram_wr_req;
        end
        chk("init_gate_no_req", {31'd0, anyreq}, 32'd0);
        sdram_init_done = 1'b1;
        @(posedge clk); #1;
        chk("init_rd_req", {31'd0, sdram_rd_req}, 32'd1);
        chk("init_rdaddr", {9'd0, sys_rdaddr}, 32'h10);
        chk("init_rdlen", {23'd0, sdrd_byte}, 32'd2);
        chk("init_wraddr_zero", {9'd0, sys_wraddr}, 32'd0);
        wait_done("init_read");

        // port 1 write 8 words at 0
        n_strobe = 0;
        p1_we = 1'b1; p1_addr = 23'h0; p1_len = 9'd8; p1_req = 1'b1;
        push_done(1'b1, 1'b0);
        @(posedge clk); #1;
        chk("wr_req_latency", {30'd0, sdram_wr_req, sdram_rd_req}, 32'd2);
        wait_done("p1_write");
        chk("wr_strobes", n_strobe, 32'd8);
        p1_we = 1'b0;

        // port 1 read
        p1_addr = 23'h20; p1_len = 9'd2; p1_req = 1'b1;
        exp_rd1.push_back(16'hA020); exp_rd1.push_back(16'hA021);
        push_done(1'b1, 1'b0);
        wait_done("p1_read");

        // port 0 readback of the written burst
        p0_addr = 23'h0; p0_len = 9'd8; p0_req = 1'b1;
        for (int i = 0; i < 8; i++) exp_rd0.push_back(16'(i));
        push_done(1'b0, 1'b0);
        wait_done("readback");

        // simultaneous requests, port 0 served last
        p0_addr = 23'h30; p0_len = 9'd1;
        p1_addr = 23'h40; p1_len = 9'd1;
        exp_rd0.push_back(16'hA030);
        exp_rd1.push_back(16'hA040);
`ifdef SDRAM_ARB_RR_EN
        push_done(1'b1, 1'b0); push_done(1'b0, 1'b0);
`else
        push_done(1'b0, 1'b0); push_done(1'b1, 1'b0);
`endif
        p0_req = 1'b1; p1_req = 1'b1;
        wait_done("simultaneous");

        // zero length
        p1_we = 1'b1; p1_addr = 23'h5; p1_len = 9'd0; p1_req = 1'b1;
        push_done(1'b1, 1'b0);
        dcyc = 0; anyreq = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            anyreq |= sdram_rd_req | sdram_wr_req;
            if (p1_done && dcyc == 0) dcyc = i;
            if (p1_done) p1_req = 1'b0;
        end
        chk("zlen_done_cycle", {31'd0, dcyc >= 1 && dcyc <= 2}, 32'd1);
        chk("zlen_no_cmd", {31'd0, anyreq}, 32'd0);
        wait_done("zero_len");
        p1_we = 1'b0;

        // beat mismatch: 5 acks for len 8, err is sticky
        short_n = 9'd5;
        p0_addr = 23'h50; p0_len = 9'd8; p0_req = 1'b1;
        for (int i = 0; i < 5; i++) exp_rd0.push_back(16'hA050 + 16'(i));
        push_done(1'b0, 1'b1);
        wait_done("mismatch");
        short_n = '0;
        p0_addr = 23'h60; p0_len = 9'd1; p0_req = 1'b1;
        exp_rd0.push_back(16'hA060);
        push_done(1'b0, 1'b1);
        wait_done("err_sticky");
        @(posedge clk); #1;
        chk("err_still_set", {31'd0, err}, 32'd1);

        // reset mid-burst
        p1_addr = 23'h70; p1_len = 9'd8; p1_req = 1'b1;
        for (int i = 0; i < 8; i++) exp_rd1.push_back(16'hA070 + 16'(i));
        push_done(1'b1, 1'b0);
        n_rv1 = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (n_rv1 >= 3) break;
        end
        chk("xfer_reached", {31'd0, n_rv1 >= 3}, 32'd1);
        reset = 1'b1; p1_req = 1'b0;
        @(posedge clk); #1;
        chk("reset_mid_outputs", outs_or(), 32'd0);
        exp_rd1.delete(); exp_done.delete();
        err_pend = 1'b0; seen0 = 0; seen1 = 0;
        reset = 1'b0;
        p0_addr = 23'h10; p0_len = 9'd2; p0_req = 1'b1;
        exp_rd0.push_back(16'hA010); exp_rd0.push_back(16'hA011);
        push_done(1'b0, 1'b0);
        wait_done("after_reset");

        repeat (3) @(posedge clk);
        chk("rd0_queue_empty", exp_rd0.size(), 32'd0);
        chk("rd1_queue_empty", exp_rd1.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port arbiter in front of `sdram_top`. It shares that controller's single burst read/write interface between a video fetch port (port 0, read-only) and a CPU port (port 1, read/write). It latches one request at a time and drives `sdram_top`'s request, address, length and data lines. It routes per-word acks and read data back to the granted port and signals burst completion. It sits between the system bus and the video fetch unit on one side and `sdram_top` on the other, all in the `sys_clk` domain.

## Interface
Parameters:
- `AW`, 23: SDRAM word address width.
- `LW`, 9: burst length width.
- `DW`, 16: data width.

Ports:
- `clk`  in  1  system clock (`sys_clk`, 100 MHz); same clock as `sdram_top`.
- `reset`  in  1  synchronous, active-high reset.
- `p0_req`  in  1  port 0 read burst request; held until `p0_done`.
- `p0_addr`  in  AW  port 0 start address.
- `p0_len`  in  LW  port 0 burst length.
- `p0_rvalid`  out  1  port 0 read word valid.
- `p0_rdata`  out  DW  port 0 read data.
- `p0_done`  out  1  port 0 burst complete (1-cycle pulse).
- `p1_req`  in  1  port 1 burst request; held until `p1_done`.
- `p1_we`  in  1  port 1 direction: 1 = write, 0 = read.
- `p1_addr`  in  AW  port 1 start address.
- `p1_len`  in  LW  port 1 burst length.
- `p1_wdata`  in  DW  port 1 write data.
- `p1_wstrobe`  out  1  port 1 write word consumed; present the next word on the following cycle.
- `p1_rvalid`  out  1  port 1 read word valid.
- `p1_rdata`  out  DW  port 1 read data.
- `p1_done`  out  1  port 1 burst complete (1-cycle pulse).
- `err`  out  1  sticky flag: beat count mismatch seen.
- `sdram_init_done`  in  1  from `sdram_top`.
- `sdram_wr_req`  out  1  to `sdram_top`.
- `sdram_rd_req`  out  1  to `sdram_top`.
- `sdram_wr_ack`  in  1  from `sdram_top`.
- `sdram_rd_ack`  in  1  from `sdram_top`.
- `sys_wraddr`  out  AW  to `sdram_top`.
- `sys_rdaddr`  out  AW  to `sdram_top`.
- `sdwr_byte`  out  LW  to `sdram_top`.
- `sdrd_byte`  out  LW  to `sdram_top`.
- `sys_data_in`  out  DW  to `sdram_top`.
- `sys_data_out`  in  DW  from `sdram_top`.

## Operation
State machine with four states: IDLE, ISSUE, XFER, DONE.
- **IDLE:** no grant is made while `sdram_init_done`=0.
  - Otherwise pick a port among the active requests; fixed priority is port 0 over port 1.
  - Latch the grant, direction, address and length into registers, then go to ISSUE.
  - A winning request with `len`=0 goes straight to DONE; no SDRAM command is issued.
- **ISSUE:** hold `sdram_rd_req` (or `sdram_wr_req`) at 1 with the latched address and length.
  - On the first cycle the matching ack is 1: drop the request, set `beats`=1, go to XFER.
- **XFER:** while the ack is 1, increment `beats`.
  - When the ack falls to 0, go to DONE.
- **DONE:** pulse the granted port's `pN_done` for 1 cycle.
  - If `beats` != latched length and length != 0, set `err`.
  - Clear the grant and return to IDLE.
- **Datapath:**
  - `sys_data_in` = `p1_wdata`, combinational.
  - `p1_wstrobe` = `sdram_wr_ack` while port 1 is granted for a write.
  - `pN_rvalid` = `sdram_rd_ack` while port N is granted; `pN_rdata` = `sys_data_out`. Data is not registered.
- **Unused lines:** the address/length output for the direction not in use is driven to 0.
- **Request rules:** a requester changing `addr`/`len`/`we` after its grant has no effect. Dropping `req` mid-burst does not abort the burst.
- **Beat counter:** `beats` is LW+1 bits wide and saturates at all-ones.

## Timing
- Reset values: all outputs 0; state IDLE; `err` 0.
- Request latency: `pN_req` seen in IDLE → `sdram_*_req` = 1 on the next cycle.
- Completion: ack falls at cycle t → `pN_done` = 1 at t+1 → IDLE at t+2. Earliest next grant is at t+2.
- Simultaneous `p0_req` and `p1_req` in IDLE: port 0 wins. Port 1 is served after that burst completes, provided port 0 has dropped `req`.
- A request arriving during XFER waits; it is not queued beyond its own held `req` level.
- Both acks high at the same time: the ack for the other direction is ignored.
- `reset` mid-burst: return to IDLE on the next edge with all outputs 0. `sdram_top` is on the same reset and also restarts.

## Configuration
- `SDRAM_ARB_RR_EN` defined: round-robin arbitration. A port that was just served has lower priority on the next grant when both ports request.
- Undefined: fixed priority, port 0 first. The CPU port can starve if video requests continuously.

## Structure
- Package `sdram_pkg`:
  - state enum (IDLE/ISSUE/XFER/DONE);
  - `SDRAM_AW`=23, `SDRAM_LW`=9, `SDRAM_DW`=16.
- One sub-module, `sdram_arb_pick`: combinational two-way grant selection plus the last-served flop used under `SDRAM_ARB_RR_EN`.

## Test plan
- **Port 1 write.** Port 1 writes `len`=8 at 0x000000, `wdata` incremented on each `p1_wstrobe`, against the `sdram_top` model.
  - Required: 8 strobes, one `p1_done`, `err`=0.
  - Reading back with port 0 gives `p0_rdata` = 0..7 across 8 `p0_rvalid` cycles.
- **Simultaneous requests.** `p0_req` and `p1_req` rise on the same cycle.
  - Fixed priority: port 0 burst runs first, then port 1.
  - `SDRAM_ARB_RR_EN` with port 0 served last: port 1 runs first.
- **Zero length.** `p1_len`=0.
  - Required: `p1_done` 2 cycles after the request; `sdram_wr_req`/`sdram_rd_req` never assert.
- **Init gating.** `sdram_init_done`=0 with `p0_req`=1.
  - Required: no SDRAM request.
  - After init rises: `sdram_rd_req` = 1 one cycle later.
- **Beat mismatch.** The model returns 5 acks for `len`=8.
  - Required: `err`=1 after `p0_done`, and it stays 1 until `reset`.
- **Reset mid-burst.** `reset` asserted during XFER.
  - Required: all outputs 0 on the next cycle; a new request after reset completes normally.
